// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
//
// Multi-cycle control FSM for the 16-bit RISC datapath. It steps each
// instruction through FETCH / DECODE / EXEC / MEM / WB, retiring one
// instruction at a time. A single shared single-port memory serves both
// instruction fetch and LW/SW data access over a req/ack handshake.
//
// Parameters
//   CNT_W        width of the retired-instruction counter
//   MEM_TIMEOUT  wait cycles tolerated before a bus error (timeout build only)
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   run          in   1 = execute; sampled in IDLE and at instruction completion
//   opcode[3:0]  in   IR[15:12], valid from DECODE onward
//   alu_zero     in   ALU zero flag, valid in EXEC
//   mem_ack      in   memory done, read data valid this cycle
//   mem_req      out  memory access request
//   mem_we       out  1 = write (SW data phase)
//   mem_sel      out  0 = instruction port (PC), 1 = data port (ALU result)
//   ir_load      out  load IR from memory read data
//   pc_en        out  PC update strobe
//   pc_src[1:0]  out  00 = PC+2, 01 = branch target, 10 = jump target
//   alu_op[1:0]  out  10 = add, 01 = subtract, 00 = function field
//   alu_src      out  1 = immediate operand
//   reg_dst      out  1 = rd, 0 = rt
//   mem_to_reg   out  1 = write back memory data
//   reg_write    out  register file write strobe
//   busy         out  1 whenever the FSM is not in IDLE
//   bus_err      out  sticky memory timeout flag
//   instr_count  out  retired instruction count, wraps at 2^CNT_W
//
// Build option
//   SEQ_WAIT_TIMEOUT_EN : when defined, a wait counter bounds every memory
//   wait; on expiry the FSM parks in ERR (bus_err=1) until reset. When
//   undefined, waits are unbounded, ERR is unreachable and bus_err is 0.
// ---------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             alu_zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             ir_load,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             busy,
    output logic             bus_err,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic             instr_done;
    logic             timeout;

    // Opcode classes; anything not explicitly listed is treated as R-type.
    logic op_lw, op_sw, op_beq, op_bne, op_j, op_r, op_mem;
    assign op_lw  = (opcode == 4'b0000);
    assign op_sw  = (opcode == 4'b0001);
    assign op_beq = (opcode == 4'b1011);
    assign op_bne = (opcode == 4'b1100);
    assign op_j   = (opcode == 4'b1101);
    assign op_r   = ~(op_lw | op_sw | op_beq | op_bne | op_j);
    assign op_mem = op_lw | op_sw;

`ifdef SEQ_WAIT_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mem_wait;

    // Count only cycles where a request is outstanding and not answered;
    // any ack or state change returns the counter to zero.
    assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ack;
    assign timeout  = mem_wait && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
    assign wait_d   = (mem_wait && !timeout) ? wait_q + 1'b1 : '0;
`else
    // No bound on memory waits in this build.
    assign timeout = 1'b0;
    if (MEM_TIMEOUT < 1) begin : g_timeout_cfg_unused
        // A non-positive MEM_TIMEOUT only matters in the timeout build.
    end
`endif

    // Next-state selection. instr_done marks the retire cycle of every
    // instruction class; the follow-on state then depends only on run.
    always_comb begin
        state_d    = state_q;
        instr_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ack)      state_d = S_DECODE;
                else if (timeout) state_d = S_ERR;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (op_mem)    state_d = S_MEM;
                else if (op_r) state_d = S_WB;
                else           instr_done = 1'b1;
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (op_lw) state_d = S_WB;
                    else       instr_done = 1'b1;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_WB:    instr_done = 1'b1;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
        if (instr_done) state_d = run ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
`ifdef SEQ_WAIT_TIMEOUT_EN
            wait_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (instr_done) count_q <= count_q + 1'b1;
`ifdef SEQ_WAIT_TIMEOUT_EN
            wait_q  <= wait_d;
`endif
        end
    end

    assign instr_count = count_q;

    // Control strobes decoded from the registered state; mem_ack, alu_zero
    // and opcode only qualify strobes inside the states that use them.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_sel    = 1'b0;
        ir_load    = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        alu_op     = 2'b00;
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        busy       = 1'b0;
        bus_err    = 1'b0;
        case (state_q)
            S_FETCH: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load = 1'b1;
                    pc_en   = 1'b1;
                end
            end
            S_DECODE: busy = 1'b1;
            S_EXEC: begin
                busy = 1'b1;
                if (op_mem) begin
                    alu_op  = 2'b10;
                    alu_src = 1'b1;
                end else if (op_beq) begin
                    alu_op = 2'b01;
                    pc_src = 2'b01;
                    pc_en  = alu_zero;
                end else if (op_bne) begin
                    alu_op = 2'b01;
                    pc_src = 2'b01;
                    pc_en  = ~alu_zero;
                end else if (op_j) begin
                    pc_src = 2'b10;
                    pc_en  = 1'b1;
                end else begin
                    reg_dst = 1'b1;
                end
            end
            S_MEM: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = op_sw;
                alu_op  = 2'b10;
                alu_src = 1'b1;
            end
            S_WB: begin
                busy       = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = op_lw;
                reg_dst    = op_r;
            end
            S_ERR: begin
                busy = 1'b1;
`ifdef SEQ_WAIT_TIMEOUT_EN
                bus_err = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: a phase-list model predicts every output
// each cycle, and directed instruction runs pin cycle counts and strobes.
module tb_multicycle_sequencer;

    localparam int TO = 4;
    localparam int P_F = 1, P_D = 2, P_E = 3, P_M = 4, P_W = 5;
    localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_BNE = 4, C_J = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [3:0]  opcode = 4'b0010;
    logic        alu_zero = 1'b0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, mem_sel, ir_load, pc_en;
    logic [1:0]  pc_src, alu_op;
    logic        alu_src, reg_dst, mem_to_reg, reg_write, busy, bus_err;
    logic [15:0] instr_count;

    multicycle_sequencer #(.CNT_W(16), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
        .ir_load(ir_load), .pc_en(pc_en), .pc_src(pc_src), .alu_op(alu_op),
        .alu_src(alu_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .busy(busy), .bus_err(bus_err), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    // ---------------- memory responder ----------------
    int fetch_delay = 0, data_delay = 0;
    bit ack_block = 0, stray_ack = 0;
    int req_cyc = 0;
    always @(posedge clk) begin
        #1;
        if (mem_req && !ack_block) begin
            if (req_cyc >= (mem_sel ? data_delay : fetch_delay)) begin
                mem_ack = 1'b1;
                req_cyc = 0;
            end else begin
                mem_ack = 1'b0;
                req_cyc++;
            end
        end else if (mem_req) begin
            mem_ack = 1'b0;
        end else begin
            mem_ack = stray_ack;
            req_cyc = 0;
        end
    end

    // ---------------- behavioural model ----------------
    // An instruction is a list of phases still to run; memory phases only
    // advance on ack. The list past FETCH is filled in once the opcode is known.
    int          ph[$];
    bit          m_active = 0, m_err = 0;
    int          m_wait = 0;
    logic [15:0] m_count = 0;

    function automatic int op_class(input logic [3:0] op);
        case (op)
            4'b0000: return C_LW;
            4'b0001: return C_SW;
            4'b1011: return C_BEQ;
            4'b1100: return C_BNE;
            4'b1101: return C_J;
            default: return C_R;
        endcase
    endfunction

    always @(posedge clk) begin
        int cur, cls;
        bit adv;
        cls = op_class(opcode);
        if (reset) begin
            m_active = 0; m_err = 0; m_wait = 0; m_count = 0; ph.delete();
        end else if (!m_err) begin
            if (!m_active) begin
                if (run) begin m_active = 1; ph = {P_F}; end
            end else begin
                cur = ph[0];
                adv = 1;
                if (cur == P_F || cur == P_M) begin
                    adv = mem_ack;
                    m_wait = mem_ack ? 0 : m_wait + 1;
`ifdef SEQ_WAIT_TIMEOUT_EN
                    if (m_wait == TO) begin m_err = 1; m_wait = 0; ph.delete(); adv = 0; end
`endif
                end
                if (adv) begin
                    if (cur == P_F) begin
                        ph = {P_D, P_E};
                        if (cls == C_LW || cls == C_SW) ph.push_back(P_M);
                        if (cls == C_LW || cls == C_R)  ph.push_back(P_W);
                    end else begin
                        void'(ph.pop_front());
                    end
                    if (ph.size() == 0) begin
                        m_count = m_count + 16'd1;
                        m_active = run;
                        if (run) ph = {P_F};
                    end
                end
            end
        end
    end

    // Outputs packed {req,we,sel,ir_load,pc_en,pc_src,alu_op,alu_src,reg_dst,mem_to_reg,reg_write,busy,bus_err}
    function automatic logic [14:0] model_out();
        logic rq = 0, we = 0, sl = 0, irl = 0, pe = 0, as = 0, rd = 0, m2r = 0, rw = 0, by = 0, be = 0;
        logic [1:0] ps = 0, ao = 0;
        int cls = op_class(opcode);
        if (m_err) begin
            by = 1; be = 1;
        end else if (m_active) begin
            by = 1;
            case (ph[0])
                P_F: begin rq = 1; irl = mem_ack; pe = mem_ack; end
                P_E: case (cls)
                    C_LW, C_SW: begin ao = 2'b10; as = 1; end
                    C_BEQ: begin ao = 2'b01; ps = 2'b01; pe = alu_zero; end
                    C_BNE: begin ao = 2'b01; ps = 2'b01; pe = !alu_zero; end
                    C_J:   begin ps = 2'b10; pe = 1; end
                    default: rd = 1;
                endcase
                P_M: begin rq = 1; sl = 1; we = (cls == C_SW); ao = 2'b10; as = 1; end
                P_W: begin rw = 1; m2r = (cls == C_LW); rd = (cls == C_R); end
                default: ;
            endcase
        end
        return {rq, we, sl, irl, pe, ps, ao, as, rd, m2r, rw, by, be};
    endfunction

    // ---------------- per-instruction tallies ----------------
    int n_cyc, n_dsel, n_we, n_rw, n_m2r, n_rd, n_pcen, n_ir;
    logic [1:0] last_src;

    task automatic clr_tally();
        n_cyc = 0; n_dsel = 0; n_we = 0; n_rw = 0; n_m2r = 0; n_rd = 0; n_pcen = 0; n_ir = 0;
        last_src = 2'b00;
    endtask

    task automatic compare_loop();
        logic [14:0] act, exp;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp = model_out();
                act = {mem_req, mem_we, mem_sel, ir_load, pc_en, pc_src, alu_op,
                       alu_src, reg_dst, mem_to_reg, reg_write, busy, bus_err};
                n_checks++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL cycle_outputs t=%0t got=%b expected=%b", $time, act, exp);
                end
                n_checks++;
                if (instr_count !== m_count) begin
                    n_fail++;
                    $display("FAIL cycle_count t=%0t got=%0d expected=%0d", $time, instr_count, m_count);
                end
                if (busy) begin
                    n_cyc++;
                    if (mem_req && mem_sel) n_dsel++;
                    if (mem_req && mem_we)  n_we++;
                    if (reg_write) n_rw++;
                    if (reg_write && mem_to_reg) n_m2r++;
                    if (reg_write && reg_dst) n_rd++;
                    if (ir_load) n_ir++;
                    if (pc_en && pc_src != 2'b00) begin n_pcen++; last_src = pc_src; end
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name);
        int i = 0;
        while (busy && i < 60) begin tick(); i++; end
        chk({name, "_done_in_time"}, int'(busy), 0);
    endtask

    task automatic wait_data_phase(input string name);
        int i = 0;
        while (!(mem_req && mem_sel) && i < 30) begin tick(); i++; end
        chk({name, "_reached_mem"}, int'(mem_req && mem_sel), 1);
    endtask

    task automatic run_one(input logic [3:0] op, input logic z, input int fd, input int md);
        opcode = op; alu_zero = z; fetch_delay = fd; data_delay = md;
        clr_tally();
        run = 1'b1;
        tick();
        run = 1'b0;
        wait_idle("instr");
    endtask

    initial begin
        logic [15:0] c0;
        int i;
        fork compare_loop(); join_none
        clr_tally();
        tick();
        chk_en = 1;
        tick();
        reset = 1'b0;
        chk("reset_outputs", int'({mem_req, mem_we, mem_sel, ir_load, pc_en, pc_src, alu_op,
                                   alu_src, reg_dst, mem_to_reg, reg_write, busy, bus_err}), 0);
        chk("reset_count", int'(instr_count), 0);

        // R-type, zero-wait fetch
        run_one(4'b0010, 1'b0, 0, 0);
        chk("r_cycles", n_cyc, 4);
        chk("r_regwrite_pulses", n_rw, 1);
        chk("r_regdst_in_wb", n_rd, 1);
        chk("r_ir_load", n_ir, 1);
        chk("r_count", int'(instr_count), 1);
        run_one(4'b1010, 1'b0, 0, 0);
        chk("op1010_cycles", n_cyc, 4);
        chk("op1010_regdst", n_rd, 1);
        run_one(4'b1111, 1'b0, 0, 0);
        chk("op1111_cycles", n_cyc, 4);

        // LW with data ack three cycles late
        run_one(4'b0000, 1'b0, 0, 3);
        chk("lw_data_cycles", n_dsel, 4);
        chk("lw_no_write", n_we, 0);
        chk("lw_mem_to_reg", n_m2r, 1);
        chk("lw_cycles", n_cyc, 8);

        run_one(4'b0011, 1'b0, 2, 0);
        chk("r_fetchwait_cycles", n_cyc, 6);

        // Branches and jump
        run_one(4'b1011, 1'b1, 0, 0);
        chk("beq_taken", n_pcen, 1);
        chk("beq_src", int'(last_src), 1);
        chk("beq_cycles", n_cyc, 3);
        run_one(4'b1011, 1'b0, 0, 0);
        chk("beq_not_taken", n_pcen, 0);
        run_one(4'b1100, 1'b1, 0, 0);
        chk("bne_not_taken", n_pcen, 0);
        run_one(4'b1100, 1'b0, 0, 0);
        chk("bne_taken", n_pcen, 1);
        run_one(4'b1101, 1'b0, 0, 0);
        chk("j_pc_en", n_pcen, 1);
        chk("j_src", int'(last_src), 2);

        run_one(4'b0001, 1'b0, 0, 0);
        chk("sw_cycles", n_cyc, 4);
        chk("sw_write_cycles", n_we, 1);
        chk("sw_no_regwrite", n_rw, 0);

        // Acks while no request is pending must be ignored
        stray_ack = 1;
        run_one(4'b0100, 1'b0, 0, 0);
        stray_ack = 0;
        chk("stray_ack_cycles", n_cyc, 4);
        chk("count_after_12", int'(instr_count), 12);

        // Back-to-back: R then J with run held across the first completion
        opcode = 4'b0101; fetch_delay = 0; clr_tally();
        c0 = m_count;
        run = 1'b1;
        tick();
        i = 0;
        while (m_count == c0 && i < 20) begin tick(); i++; end
        opcode = 4'b1101;
        run = 1'b0;
        wait_idle("b2b");
        chk("b2b_cycles", n_cyc, 7);
        chk("b2b_count", int'(instr_count), 14);

        // run dropped while SW waits for its data ack
        opcode = 4'b0001; fetch_delay = 0; data_delay = 2; clr_tally();
        run = 1'b1;
        tick();
        wait_data_phase("sw_drop");
        run = 1'b0;
        wait_idle("sw_drop");
        chk("sw_drop_write_cycles", n_we, 3);
        chk("sw_drop_count", int'(instr_count), 15);
        chk("sw_drop_busy", int'(busy), 0);

        // Reset held three cycles mid-MEM, with an ack in flight
        opcode = 4'b0000; data_delay = 0;
        run = 1'b1;
        tick();
        wait_data_phase("rst_mid");
        chk("rst_mid_ack_in_flight", int'(mem_ack), 1);
        reset = 1'b1;
        tick();
        chk("rst_mid_req", int'(mem_req), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_count", int'(instr_count), 0);
        tick();
        tick();
        reset = 1'b0;
        run = 1'b0;
        tick();
        chk("rst_release_idle", int'(busy), 0);

`ifdef SEQ_WAIT_TIMEOUT_EN
        // Fetch never acknowledged: ERR after TO wait cycles
        ack_block = 1; opcode = 4'b0010;
        run = 1'b1;
        tick();
        for (int k = 0; k < TO - 1; k++) begin
            tick();
            chk("to_still_fetch", int'({mem_req, bus_err}), 2);
        end
        tick();
        chk("to_err_flags", int'({mem_req, busy, bus_err}), 3);
        run = 1'b0; ack_block = 0; stray_ack = 1;
        tick(); tick(); tick();
        chk("to_err_sticky", int'(bus_err), 1);
        stray_ack = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("to_err_cleared", int'({busy, bus_err}), 0);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
